irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 159 +++++++++++++++
 tb/tb_irq_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//
// Edge-triggered, masked, fixed-priority interrupt controller. It signals the
// control unit with a toggle-encoded request line: every level change on
// `interrupt` is one new request.
//
// Ports
//   clock       in   1  single clock, rising-edge active
//   reset       in   1  asynchronous, active-high reset
//   irq_in      in   4  external request lines, rising edge = request,
//                       bit 0 has the highest priority
//   mask_we     in   1  load the mask register from mask_wdata
//   mask_wdata  in   4  new mask value, 1 = line enabled
//   irq_taken   in   1  pulse: control unit entered its first interrupt state
//   irq_return  in   1  pulse: control unit executed its interrupt return
//   interrupt   out  1  toggle-encoded request to the control unit
//   irq_vector  out  2  index of the request being signalled or serviced
//   irq_pending out  4  pending-request register
//   irq_busy    out  1  high while in SIGNAL or SERVICE
//
// Configuration
//   IRQ_SYNC_EN  when defined, each irq_in bit passes a 2-flop synchronizer
//                before edge detection. When undefined, irq_in feeds the
//                edge detector directly.
// ---------------------------------------------------------------------------
module irq_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] irq_in,
  input  logic       mask_we,
  input  logic [3:0] mask_wdata,
  input  logic       irq_taken,
  input  logic       irq_return,
  output logic       interrupt,
  output logic [1:0] irq_vector,
  output logic [3:0] irq_pending,
  output logic       irq_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SIGNAL  = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       interrupt_q, interrupt_d;
  logic [1:0] vector_q, vector_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] prev_q;
  logic [1:0] settle_q;
  logic [3:0] line_s;
  logic [3:0] edge_s;
  logic [3:0] clr_s;
  logic [3:0] enabled_s;
  logic       armed_s;

  // Lowest-index set bit wins.
  function automatic logic [1:0] pick_lowest(input logic [3:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) idx = 2'(i);
    end
    return idx;
  endfunction

`ifdef IRQ_SYNC_EN
  // Two-flop synchronizer; the edge detector then needs one more flop, so a
  // line held high across reset release reaches the detector three edges in.
  localparam logic [1:0] SETTLE = 2'd3;
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign line_s = sync2_q;
`else
  localparam logic [1:0] SETTLE = 2'd1;
  assign line_s = irq_in;
`endif

  // After reset the edge registers start at 0, so a line already high would
  // look like a fresh rising edge. Detection stays disarmed until the
  // previous-value registers have caught up with the real line levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      settle_q <= 2'd0;
    end else if (settle_q != SETTLE) begin
      settle_q <= settle_q + 2'd1;
    end
  end

  assign armed_s   = (settle_q == SETTLE);
  assign edge_s    = line_s & ~prev_q & {4{armed_s}};
  assign enabled_s = pending_q & mask_q;

  always_comb begin
    state_d     = state_q;
    interrupt_d = interrupt_q;
    vector_d    = vector_q;
    clr_s       = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (enabled_s != 4'b0000) begin
          state_d     = SIGNAL;
          interrupt_d = ~interrupt_q;
          vector_d    = pick_lowest(enabled_s);
        end
      end
      SIGNAL: begin
        if (irq_taken) begin
          state_d            = SERVICE;
          clr_s[vector_q]    = 1'b1;
        end
      end
      SERVICE: begin
        if (irq_return) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new edge on the cycle its bit is cleared keeps the bit set.
    pending_d = (pending_q & ~clr_s) | edge_s;
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      interrupt_q <= 1'b0;
      vector_q    <= 2'd0;
      pending_q   <= 4'b0000;
      mask_q      <= 4'b1111;
      prev_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
      vector_q    <= vector_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      prev_q      <= line_s;
    end
  end

  assign interrupt   = interrupt_q;
  assign irq_vector  = vector_q;
  assign irq_pending = pending_q;
  assign irq_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_in = 4'b0000;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = 4'b0000;
  logic       irq_taken = 1'b0;
  logic       irq_return = 1'b0;
  logic       interrupt;
  logic [1:0] irq_vector;
  logic [3:0] irq_pending;
  logic       irq_busy;

  int checks = 0;
  int errors = 0;
  logic       exp_int = 1'b0;
  logic       prev_int = 1'b0;
  logic [1:0] exp_vec_q[$];

  irq_controller dut (
    .clock      (clock),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_taken  (irq_taken),
    .irq_return (irq_return),
    .interrupt  (interrupt),
    .irq_vector (irq_vector),
    .irq_pending(irq_pending),
    .irq_busy   (irq_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_taken();
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
  endtask

  task automatic pulse_return();
    irq_return = 1'b1;
    tick();
    irq_return = 1'b0;
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  // Expect a toggle at the edge just passed.
  task automatic expect_toggle(input string tag, input logic [1:0] vec);
    exp_int = ~exp_int;
    check({tag, "_int"}, 8'(interrupt), 8'(exp_int));
    check({tag, "_vec"}, 8'(irq_vector), 8'(vec));
    check({tag, "_busy"}, 8'(irq_busy), 8'd1);
  endtask

  // Scoreboard monitor: every toggle of interrupt consumes one expected vector.
  always @(negedge clock) begin
    if (reset) begin
      prev_int <= interrupt;
    end else if (interrupt !== prev_int) begin
      prev_int <= interrupt;
      if (exp_vec_q.size() == 0) check("sb_unexpected_toggle", 8'd1, 8'd0);
      else check("sb_vector", 8'(irq_vector), 8'(exp_vec_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    ticks(2);
    check("rst_int", 8'(interrupt), 8'd0);
    check("rst_vec", 8'(irq_vector), 8'd0);
    check("rst_pend", 8'(irq_pending), 8'd0);
    check("rst_busy", 8'(irq_busy), 8'd0);
    reset = 1'b0;
    ticks(5);

    // Basic request on line 2, with latency check
    exp_vec_q.push_back(2'd2);
    irq_in = 4'b0100;
    ticks(LAT);
    check("basic_pend", 8'(irq_pending), 8'h4);
    check("basic_lat_int", 8'(interrupt), 8'(exp_int));
    check("basic_lat_busy", 8'(irq_busy), 8'd0);
    tick();
    expect_toggle("basic", 2'd2);
    pulse_return();
    check("basic_ret_ignored", 8'(irq_busy), 8'd1);
    pulse_taken();
    check("basic_taken_pend", 8'(irq_pending), 8'h0);
    check("basic_service_busy", 8'(irq_busy), 8'd1);
    pulse_return();
    check("basic_idle_busy", 8'(irq_busy), 8'd0);
    check("basic_idle_vec_hold", 8'(irq_vector), 8'd2);
    irq_in = 4'b0000;
    ticks(LAT + 2);

    // Priority: lines 3 and 1 together
    exp_vec_q.push_back(2'd1);
    exp_vec_q.push_back(2'd3);
    irq_in = 4'b1010;
    ticks(LAT);
    check("prio_pend", 8'(irq_pending), 8'hA);
    tick();
    expect_toggle("prio1", 2'd1);
    pulse_taken();
    check("prio_pend_after", 8'(irq_pending), 8'h8);
    pulse_return();
    check("prio_dwell_busy", 8'(irq_busy), 8'd0);
    check("prio_dwell_int", 8'(interrupt), 8'(exp_int));
    tick();
    expect_toggle("prio2", 2'd3);
    pulse_taken();
    pulse_return();
    irq_in = 4'b0000;
    ticks(LAT + 2);

    // Mask gates selection only
    write_mask(4'b1110);
    irq_in = 4'b0001;
    ticks(LAT + 2);
    check("mask_pend", 8'(irq_pending), 8'h1);
    check("mask_no_toggle", 8'(interrupt), 8'(exp_int));
    check("mask_idle", 8'(irq_busy), 8'd0);
    exp_vec_q.push_back(2'd0);
    write_mask(4'b1111);
    check("mask_load_no_toggle", 8'(interrupt), 8'(exp_int));
    tick();
    expect_toggle("mask", 2'd0);
    write_mask(4'b0000);
    check("mask_no_retract_int", 8'(interrupt), 8'(exp_int));
    check("mask_no_retract_busy", 8'(irq_busy), 8'd1);
    pulse_taken();
    pulse_return();
    write_mask(4'b1111);
    irq_in = 4'b0000;
    ticks(LAT + 2);
    check("mask_done_pend", 8'(irq_pending), 8'h0);

    // Collision: new edge on the taken cycle
    exp_vec_q.push_back(2'd1);
    exp_vec_q.push_back(2'd1);
    irq_in = 4'b0010;
    ticks(LAT + 1);
    expect_toggle("coll1", 2'd1);
    irq_in = 4'b0000;
    ticks(LAT + 1);
    irq_in = 4'b0010;
    ticks(LAT - 1);
    pulse_taken();
    check("coll_pend_kept", 8'(irq_pending), 8'h2);
    pulse_return();
    check("coll_dwell_busy", 8'(irq_busy), 8'd0);
    tick();
    expect_toggle("coll2", 2'd1);
    pulse_taken();
    check("coll_pend_clear", 8'(irq_pending), 8'h0);
    pulse_return();
    irq_in = 4'b0000;
    ticks(LAT + 2);

    // Reset mid-SERVICE with line 0 held high
    exp_vec_q.push_back(2'd0);
    irq_in = 4'b0001;
    ticks(LAT + 1);
    expect_toggle("rstsvc", 2'd0);
    pulse_taken();
    reset = 1'b1;
    #1;
    exp_int = 1'b0;
    check("rstsvc_int", 8'(interrupt), 8'd0);
    check("rstsvc_pend", 8'(irq_pending), 8'h0);
    check("rstsvc_busy", 8'(irq_busy), 8'd0);
    ticks(2);
    reset = 1'b0;
    ticks(8);
    check("held_no_pend", 8'(irq_pending), 8'h0);
    check("held_no_toggle", 8'(interrupt), 8'd0);
    check("held_idle", 8'(irq_busy), 8'd0);
    irq_in = 4'b0000;
    ticks(LAT + 1);
    exp_vec_q.push_back(2'd0);
    irq_in = 4'b0001;
    ticks(LAT);
    check("rearm_pend", 8'(irq_pending), 8'h1);
    tick();
    expect_toggle("rearm", 2'd0);
    pulse_taken();
    pulse_return();
    irq_in = 4'b0000;
    ticks(3);

    check("sb_empty", 8'(exp_vec_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
